// File: rtl/scanchain_reader_pkg.sv
// Shared definitions for the scan-chain read-back path: FSM states and the
// scan clock timing helpers that the writer block also uses.
package scanchain_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPTURE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int MIN_CLOCKS_PER_SCAN_CLK = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // scan_clk is low for the first half of a period and high for the second.
  function automatic int half_period(input int clocks_per_scan_clk);
    return clocks_per_scan_clk / 2;
  endfunction

  // scan_out is sampled in the last fabric cycle of the high phase, where the
  // chip output has had the longest time to settle.
  function automatic int sample_phase(input int clocks_per_scan_clk);
    return clocks_per_scan_clk - 1;
  endfunction

endpackage

// File: rtl/scanchain_reader_if.sv
// Host-side read request / read response channel of the scan-chain reader.
interface scanchain_reader_if #(
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 169
);
  logic                    read_valid;
  logic                    read_ready;
  logic [ADDR_BITS-1:0]    read_addr;
  logic                    rdata_valid;
  logic                    rdata_ready;
  logic [PAYLOAD_BITS-1:0] read_data;

  modport master (
    output read_valid, read_addr, rdata_ready,
    input  read_ready, rdata_valid, read_data
  );

  modport slave (
    input  read_valid, read_addr, rdata_ready,
    output read_ready, rdata_valid, read_data
  );
endinterface

// File: rtl/scanchain_reader_scan_clk_gen.sv
// Slow scan clock generator: a phase counter that runs only while enabled and
// flags the period end and the scan_out sample point.
module scanchain_reader_scan_clk_gen
  import scanchain_reader_pkg::*;
#(
  parameter int CLOCKS_PER_SCAN_CLK = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic scan_clk,
  output logic period_end,
  output logic sample_tick
);
  localparam int PHASE_W = $clog2(CLOCKS_PER_SCAN_CLK);
  localparam logic [PHASE_W-1:0] LAST_PHASE   = PHASE_W'(CLOCKS_PER_SCAN_CLK - 1);
  localparam logic [PHASE_W-1:0] HIGH_PHASE   = PHASE_W'(half_period(CLOCKS_PER_SCAN_CLK));
  localparam logic [PHASE_W-1:0] SAMPLE_PHASE = PHASE_W'(sample_phase(CLOCKS_PER_SCAN_CLK));

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;

  // NOTE: every signal written in always_comb gets a value on every path, so
  // no latch can be inferred.
  always_comb begin
    phase_next = phase + PHASE_W'(1);
    if (phase == LAST_PHASE) phase_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      scan_clk <= 1'b0;
    end else if (!enable) begin
      phase    <= '0;
      scan_clk <= 1'b0;
    end else begin
      phase    <= phase_next;
      scan_clk <= (phase_next >= HIGH_PHASE);
    end
  end

  assign period_end  = enable && (phase == LAST_PHASE);
  assign sample_tick = enable && (phase == SAMPLE_PHASE);

endmodule

// File: rtl/scanchain_reader.sv
// Scan-chain read-back: shifts an address into the chip, pulses capture, then
// shifts PAYLOAD_BITS out of scan_out (LSB first) into a parallel result word.
module scanchain_reader
  import scanchain_reader_pkg::*;
#(
  parameter int CLOCK_FREQ          = 100_000_000,
  parameter int CLOCKS_PER_SCAN_CLK = 100_000,
  parameter int ADDR_BITS           = 12,
  parameter int PAYLOAD_BITS        = 169
) (
  input  logic                   clk,
  input  logic                   reset,
  scanchain_reader_if.slave      host,
  output logic                   scan_clk,
  output logic                   scan_en,
  output logic                   scan_in,
  output logic                   scan_capture,
  input  logic                   scan_out
);
  localparam int BIT_W = $clog2(max_int(ADDR_BITS, PAYLOAD_BITS) + 1);
  localparam logic [BIT_W-1:0] ADDR_LAST    = BIT_W'(ADDR_BITS - 1);
  localparam logic [BIT_W-1:0] PAYLOAD_LAST = BIT_W'(PAYLOAD_BITS - 1);

  if (CLOCKS_PER_SCAN_CLK < MIN_CLOCKS_PER_SCAN_CLK || (CLOCKS_PER_SCAN_CLK % 2) != 0 ||
      CLOCK_FREQ < CLOCKS_PER_SCAN_CLK || ADDR_BITS < 2 || PAYLOAD_BITS < 2) begin : g_bad_params
    $error("scanchain_reader: unsupported parameter combination");
  end

  state_t                  state;
  logic [ADDR_BITS-1:0]    addr_sr;
  logic [PAYLOAD_BITS-1:0] payload_sr;
  logic [PAYLOAD_BITS-1:0] payload_next;
  logic [BIT_W-1:0]        bit_cnt;
  logic                    scan_out_meta;
  logic                    scan_out_sync;
  logic                    scan_active;
  logic                    period_end;
  logic                    sample_tick;

  assign scan_active = (state == ST_ADDR) || (state == ST_CAPTURE) || (state == ST_SHIFT);

  scanchain_reader_scan_clk_gen #(
    .CLOCKS_PER_SCAN_CLK(CLOCKS_PER_SCAN_CLK)
  ) u_scan_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .enable     (scan_active),
    .scan_clk   (scan_clk),
    .period_end (period_end),
    .sample_tick(sample_tick)
  );

  // scan_out comes from the chip's scan_clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_out_meta <= 1'b0;
      scan_out_sync <= 1'b0;
    end else begin
      scan_out_meta <= scan_out;
      scan_out_sync <= scan_out_meta;
    end
  end

  // First sampled bit travels down to bit 0 after PAYLOAD_BITS samples.
  assign payload_next = sample_tick ? {scan_out_sync, payload_sr[PAYLOAD_BITS-1:1]} : payload_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      addr_sr          <= '0;
      payload_sr       <= '0;
      bit_cnt          <= '0;
      scan_en          <= 1'b0;
      scan_in          <= 1'b0;
      scan_capture     <= 1'b0;
      host.read_ready  <= 1'b1;
      host.rdata_valid <= 1'b0;
      host.read_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host.read_valid) begin
            state           <= ST_ADDR;
            host.read_ready <= 1'b0;
            scan_en         <= 1'b1;
            scan_in         <= host.read_addr[ADDR_BITS-1];
            addr_sr         <= {host.read_addr[ADDR_BITS-2:0], 1'b0};
            bit_cnt         <= '0;
          end
        end
        ST_ADDR: begin
          if (period_end) begin
            if (bit_cnt == ADDR_LAST) begin
              state        <= ST_CAPTURE;
              bit_cnt      <= '0;
              scan_en      <= 1'b0;
              scan_in      <= 1'b0;
              scan_capture <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              scan_in <= addr_sr[ADDR_BITS-1];
              addr_sr <= {addr_sr[ADDR_BITS-2:0], 1'b0};
            end
          end
        end
        ST_CAPTURE: begin
          if (period_end) begin
            state        <= ST_SHIFT;
            scan_capture <= 1'b0;
            scan_en      <= 1'b1;
          end
        end
        ST_SHIFT: begin
          payload_sr <= payload_next;
          if (period_end) begin
            if (bit_cnt == PAYLOAD_LAST) begin
              state            <= ST_DONE;
              scan_en          <= 1'b0;
              host.read_data   <= payload_next;
              host.rdata_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (host.rdata_ready) begin
            state            <= ST_IDLE;
            host.rdata_valid <= 1'b0;
            host.read_ready  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scanchain_reader.sv
// Self-checking bench for scanchain_reader: a behavioural chip model feeds
// scan_out, and each read is checked against the scan edge sequence it implies.
module tb_scanchain_reader;
  localparam int N        = 8;
  localparam int A        = 4;
  localparam int P        = 8;
  localparam int HALF     = N / 2;
  localparam int READ_EDGES = A + 1 + P;
  localparam int DONE_CYC = 1 + READ_EDGES * N;
  localparam int TIMEOUT  = 4 * DONE_CYC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scan_clk, scan_en, scan_in, scan_capture;
  logic scan_out = 1'b0;

  scanchain_reader_if #(.ADDR_BITS(A), .PAYLOAD_BITS(P)) host_if ();

  scanchain_reader #(
    .CLOCK_FREQ(100_000_000), .CLOCKS_PER_SCAN_CLK(N), .ADDR_BITS(A), .PAYLOAD_BITS(P)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .host        (host_if),
    .scan_clk    (scan_clk),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_capture(scan_capture),
    .scan_out    (scan_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Chip model: captures chip_payload on a capture rising edge, shifts on each
  // enabled rising edge, and launches the next bit onto scan_out after the
  // falling edge with a random skew.
  typedef struct packed { logic en; logic cap; logic din; } edge_t;
  edge_t edge_log[$];
  logic [P-1:0] chip_payload = '0;
  logic [P-1:0] chain = '0;

  always @(posedge scan_clk) begin
    edge_log.push_back('{en: scan_en, cap: scan_capture, din: scan_in});
    if (scan_capture) chain = chip_payload;
    else if (scan_en) chain = chain >> 1;
  end

  always @(negedge scan_clk) begin
    int unsigned skew;
    skew = $urandom_range(HALF - 3);
    repeat (skew) @(posedge clk);
    #2 scan_out = chain[0];
  end

  logic prev_clk = 1'b0, prev_en = 1'b0, prev_in = 1'b0, prev_cap = 1'b0;
  int stability_violations = 0;
  always @(negedge clk) begin
    if (scan_clk === 1'b1 && prev_clk === 1'b1 &&
        (scan_en !== prev_en || scan_in !== prev_in || scan_capture !== prev_cap))
      stability_violations++;
    prev_clk = scan_clk;
    prev_en  = scan_en;
    prev_in  = scan_in;
    prev_cap = scan_capture;
  end

  task automatic do_request(input logic [A-1:0] addr, input logic [P-1:0] payload, input string tag);
    checks++;
    if (host_if.read_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready_before: read_ready=%b required 1", tag, host_if.read_ready);
    end
    chip_payload       = payload;
    host_if.read_addr  = addr;
    host_if.read_valid = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    host_if.read_valid = 1'b0;
    host_if.read_addr  = ~addr;
    checks++;
    if (host_if.read_ready !== 1'b0) begin
      errors++; $display("FAIL %s_ready_after: read_ready=%b required 0", tag, host_if.read_ready);
    end
  endtask

  task automatic wait_result(input int pulse_at, input logic [A-1:0] other_addr, input bit keep_valid,
                             output int clk_bad, output int ready_bad);
    clk_bad = 0;
    ready_bad = 0;
    while (host_if.rdata_valid !== 1'b1 && cyc < TIMEOUT) begin
      if (scan_clk !== (((cyc - 1) % N) >= HALF)) clk_bad++;
      if (host_if.read_ready !== 1'b0) ready_bad++;
      if (!keep_valid) begin
        if (cyc >= pulse_at && cyc < pulse_at + 3) begin
          host_if.read_valid = 1'b1;
          host_if.read_addr  = other_addr;
        end else begin
          host_if.read_valid = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!keep_valid) host_if.read_valid = 1'b0;
  endtask

  task automatic check_result(input logic [P-1:0] payload, input int clk_bad, input int ready_bad,
                              input string tag);
    checks++;
    if (cyc !== DONE_CYC) begin
      errors++; $display("FAIL %s_latency: rdata_valid at cycle %0d required %0d", tag, cyc, DONE_CYC);
    end
    checks++;
    if (host_if.read_data !== payload) begin
      errors++; $display("FAIL %s_data: read_data=%h required %h", tag, host_if.read_data, payload);
    end
    checks++;
    if (clk_bad != 0 || ready_bad != 0 || {scan_clk, scan_en, scan_capture} !== 3'b000) begin
      errors++;
      $display("FAIL %s_pins: clk_bad=%0d ready_bad=%0d pins=%b required 0 0 000",
               tag, clk_bad, ready_bad, {scan_clk, scan_en, scan_capture});
    end
  endtask

  task automatic check_edges(input logic [A-1:0] addr, input bit expect_last, input string tag);
    edge_t exp_e;
    int bad = 0;
    checks++;
    if (edge_log.size() < READ_EDGES) begin
      errors++; $display("FAIL %s_edge_count: got %0d edges required %0d", tag, edge_log.size(), READ_EDGES);
      edge_log.delete();
      return;
    end
    for (int i = 0; i < READ_EDGES; i++) begin
      if (i < A) exp_e = '{en: 1'b1, cap: 1'b0, din: addr[A-1-i]};
      else if (i == A) exp_e = '{en: 1'b0, cap: 1'b1, din: 1'b0};
      else exp_e = '{en: 1'b1, cap: 1'b0, din: 1'b0};
      if (edge_log[0] !== exp_e) bad++;
      void'(edge_log.pop_front());
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s_edge_seq: %0d wrong scan edges required 0", tag, bad);
    end
    if (expect_last) begin
      checks++;
      if (edge_log.size() != 0) begin
        errors++; $display("FAIL %s_extra_edges: got %0d extra edges required 0", tag, edge_log.size());
      end
    end
  endtask

  task automatic consume(input string tag);
    host_if.rdata_ready = 1'b1;
    @(posedge clk); #1;
    host_if.rdata_ready = 1'b0;
    checks++;
    if (host_if.rdata_valid !== 1'b0 || host_if.read_ready !== 1'b1) begin
      errors++; $display("FAIL %s_consume: rdata_valid=%b read_ready=%b required 0 1",
                         tag, host_if.rdata_valid, host_if.read_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    host_if.read_valid  = 1'b0;
    host_if.rdata_ready = 1'b0;
    host_if.read_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({scan_clk, scan_en, scan_in, scan_capture, host_if.rdata_valid, host_if.read_ready} !== 6'b000001) begin
      errors++; $display("FAIL reset_pins: got %b required 000001",
        {scan_clk, scan_en, scan_in, scan_capture, host_if.rdata_valid, host_if.read_ready});
    end
    checks++;
    if (host_if.read_data !== '0) begin
      errors++; $display("FAIL reset_data: read_data=%h required 0", host_if.read_data);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    edge_log.delete();
  endtask

  task automatic test_basic();
    int clk_bad, ready_bad;
    do_request(4'hA, 8'h5C, "basic");
    wait_result(-100, '0, 1'b0, clk_bad, ready_bad);
    check_result(8'h5C, clk_bad, ready_bad, "basic");
    check_edges(4'hA, 1'b1, "basic");
  endtask

  task automatic test_hold();
    int bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (host_if.rdata_valid !== 1'b1 || host_if.read_data !== 8'h5C || host_if.read_ready !== 1'b0 ||
          {scan_clk, scan_en, scan_capture} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
    end
    consume("hold");
    checks++;
    if (edge_log.size() != 0) begin
      errors++; $display("FAIL hold_edges: got %0d scan edges required 0", edge_log.size());
    end
  endtask

  task automatic test_ignore();
    logic [A-1:0] a;
    logic [P-1:0] p;
    int clk_bad, ready_bad, bad = 0;
    a = A'($urandom);
    p = P'($urandom);
    do_request(a, p, "ignore");
    wait_result(70, ~a, 1'b0, clk_bad, ready_bad);
    check_result(p, clk_bad, ready_bad, "ignore");
    check_edges(a, 1'b1, "ignore");
    consume("ignore");
    repeat (10) begin
      @(posedge clk); #1;
      if (scan_clk !== 1'b0 || host_if.read_ready !== 1'b1 || host_if.rdata_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || edge_log.size() != 0) begin
      errors++; $display("FAIL ignore_no_queue: bad=%0d edges=%0d required 0 0", bad, edge_log.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [A-1:0] a;
    logic [P-1:0] p;
    int clk_bad, ready_bad;
    do_request(A'($urandom), P'($urandom), "rstmid");
    while (cyc < 70) begin
      @(posedge clk); #1;
      cyc++;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({scan_clk, scan_en, scan_in, scan_capture, host_if.rdata_valid, host_if.read_ready} !== 6'b000001 ||
        host_if.read_data !== '0) begin
      errors++; $display("FAIL rstmid_pins: got %b data=%h required 000001 data=00",
        {scan_clk, scan_en, scan_in, scan_capture, host_if.rdata_valid, host_if.read_ready}, host_if.read_data);
    end
    @(negedge clk) reset = 1'b0;
    edge_log.delete();
    @(posedge clk); #1;
    a = A'($urandom);
    p = P'($urandom);
    do_request(a, p, "rstmid_after");
    wait_result(-100, '0, 1'b0, clk_bad, ready_bad);
    check_result(p, clk_bad, ready_bad, "rstmid_after");
    check_edges(a, 1'b1, "rstmid_after");
    consume("rstmid_after");
  endtask

  task automatic test_back_to_back();
    logic [A-1:0] a;
    int clk_bad, ready_bad;
    a = A'($urandom);
    host_if.rdata_ready = 1'b1;
    host_if.read_addr   = a;
    host_if.read_valid  = 1'b1;
    chip_payload        = 8'h01;
    @(posedge clk); #1;
    cyc = 1;
    wait_result(-100, '0, 1'b1, clk_bad, ready_bad);
    check_result(8'h01, clk_bad, ready_bad, "b2b_first");
    chip_payload = 8'h80;
    @(posedge clk); #1;
    checks++;
    if (host_if.rdata_valid !== 1'b0 || host_if.read_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: rdata_valid=%b read_ready=%b required 0 1",
                         host_if.rdata_valid, host_if.read_ready);
    end
    @(posedge clk); #1;
    cyc = 1;
    wait_result(-100, '0, 1'b1, clk_bad, ready_bad);
    host_if.read_valid = 1'b0;
    check_result(8'h80, clk_bad, ready_bad, "b2b_second");
    check_edges(a, 1'b0, "b2b_first");
    check_edges(a, 1'b1, "b2b_second");
    @(posedge clk); #1;
    host_if.rdata_ready = 1'b0;
    checks++;
    if (host_if.rdata_valid !== 1'b0 || host_if.read_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_end: rdata_valid=%b read_ready=%b required 0 1",
                         host_if.rdata_valid, host_if.read_ready);
    end
  endtask

  task automatic test_skew_random();
    logic [A-1:0] a;
    logic [P-1:0] p;
    int clk_bad, ready_bad;
    for (int i = 0; i < 4; i++) begin
      a = A'($urandom);
      p = P'($urandom);
      do_request(a, p, "skew");
      wait_result(-100, '0, 1'b0, clk_bad, ready_bad);
      check_result(p, clk_bad, ready_bad, "skew");
      check_edges(a, 1'b1, "skew");
      consume("skew");
    end
  endtask

  task automatic test_stability();
    checks++;
    if (stability_violations != 0) begin
      errors++; $display("FAIL pin_stability: %0d changes while scan_clk high required 0", stability_violations);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    test_skew_random();
    test_stability();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
